// File: rtl/fcvt_ws_result_stage.sv
// FCVT.W.S result stage: derives NV/NX, forces NaN/overflow results and
// buffers entries in a small FIFO toward integer writeback.
module fcvt_ws_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float_in,
  input  logic [2:0]       rm,
  input  logic [31:0]      conv_result,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_fflags
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic             sign;
  logic [7:0]       exp_f;
  logic [22:0]      man;
  logic [22:0]      frac_mask;
  logic [31:0]      sat;
  logic             nv;
  logic             nx;
  logic [31:0]      res;

  logic [31:0]      res_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [4:0]       flg_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // The converter has already applied the rounding mode; flags depend only on the operand.
  logic unused_rm;
  assign unused_rm = ^rm;

  assign sign  = float_in[31];
  assign exp_f = float_in[30:23];
  assign man   = float_in[22:0];

  always_comb begin
    nv        = 1'b0;
    nx        = 1'b0;
    res       = conv_result;
    frac_mask = '0;
    sat       = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (exp_f == 8'hFF) begin
      nv  = 1'b1;
      res = (man != '0) ? 32'h7FFF_FFFF : sat;
    end else if (exp_f >= 8'd158) begin
      if (sign && exp_f == 8'd158 && man == '0) begin
        res = 32'h8000_0000;
      end else begin
        nv  = 1'b1;
        res = sat;
      end
    end else if (exp_f == '0 && man == '0) begin
      res = '0;
    end else if (exp_f < 8'd127) begin
      nx = 1'b1;
    end else if (exp_f < 8'd150) begin
      // Mantissa bits below the binary point are m[149-e:0].
      frac_mask = 23'((24'd1 << (8'd150 - exp_f)) - 24'd1);
      nx        = |(man & frac_mask);
    end
  end

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_result = out_valid ? res_q[rptr_q] : '0;
  assign out_tag    = out_valid ? tag_q[rptr_q] : '0;
  assign out_fflags = out_valid ? flg_q[rptr_q] : '0;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        res_q[wptr_q] <= res;
        tag_q[wptr_q] <= in_tag;
        flg_q[wptr_q] <= {nv, 3'b000, nx};
      end
    end
  end

endmodule

// File: doc/fcvt_ws_result_stage.md
Name: fcvt_ws_result_stage

Overview:
- Registered result stage directly downstream of the combinational FCVT.W.S converter.
- Takes the converter's integer result together with the original float operand, rm and destination tag.
- Computes the RISC-V fflags (NV, NX) and forces the architecturally correct NaN/overflow result.
- Buffers results in a small FIFO with valid/ready handshake toward integer writeback, so converter throughput is decoupled from writeback stalls.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, >=2).
- TAG_W, 5, width of the destination register tag carried alongside each result.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  input  1  upstream has a conversion to deliver.
- in_ready  output  1  stage can accept this cycle.
- float_in  input  32  IEEE-754 single operand that was converted.
- rm  input  3  resolved rounding mode used by the converter (000..100).
- conv_result  input  32  raw integer result from the converter.
- in_tag  input  TAG_W  destination register tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head entry.
- out_result  output  32  final integer result.
- out_tag  output  TAG_W  tag of the head entry.
- out_fflags  output  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - count=0, read and write pointers=0.
  - out_valid=0, out_result=0, out_tag=0, out_fflags=0.
  - in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
  - in_ready = (count != DEPTH). There is no full-bypass, so a push is never accepted while full, even if a pop occurs that cycle.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Latency:
  - An entry accepted at edge N is visible on the outputs (out_valid=1) after edge N, i.e. one cycle, when the FIFO was empty.
  - There is no combinational in-to-out path.
- Output data:
  - Outputs come from the head entry's registers.
  - When count==0, out_result, out_tag and out_fflags read 0.
  - Output values must remain stable while out_valid && !out_ready.
- Flag and result computation (combinational on input, registered at push). Definitions: e=float_in[30:23], m=float_in[22:0], s=float_in[31].
  - NaN (e==255, m!=0): NV=1, result=0x7FFFFFFF.
  - Inf (e==255, m==0): NV=1, result = s ? 0x80000000 : 0x7FFFFFFF.
  - e>=158:
    - Exactly -2^31 (s=1, e==158, m==0) is valid: NV=0, NX=0, result=0x80000000.
    - Otherwise NV=1, result saturated by sign as for Inf.
  - Zero (e==0, m==0): flags 0, result=0.
  - e<127 and nonzero (including subnormals): NX=1, result=conv_result.
  - 127<=e<150: NX = OR of m[149-e:0]; result=conv_result.
  - 150<=e<158: flags 0, result=conv_result.
  - NX=0 whenever NV=1.
- Flush:
  - Synchronously clears count and both pointers; out_valid=0 the next cycle.
  - Flush has priority over a same-cycle push (the push is dropped) and a same-cycle pop.
  - in_ready stays asserted during flush; a flushed push is not retried by this block.
- Reset mid-operation: identical to flush, plus all output registers cleared to 0.

Test Plan:
- float_in=0x40490FDB (3.14159), rm=001, conv_result=3, out_ready=1 -> one cycle later out_valid=1, out_result=3, out_fflags=0x01 (NX).
- float_in=0x7FC00000 (qNaN), conv_result=0x7FFFFFFF -> out_result=0x7FFFFFFF, out_fflags=0x10. Repeat with float_in=0xFF800000 (-inf) -> out_result=0x80000000, out_fflags=0x10.
- Boundary: float_in=0xCF000000 (-2^31) -> out_result=0x80000000, flags 0x00. float_in=0x4F000000 (+2^31) -> 0x7FFFFFFF, flags 0x10. float_in=0x42280000 (42.0) with conv_result=42 -> 42, flags 0x00.
- Backpressure: hold out_ready=0, push 3 back-to-back with DEPTH=2 -> in_ready=0 after 2 accepts, third held upstream. Then set out_ready=1 -> results drain in order with stable data while stalled; the third is accepted the cycle after the first pop.
- Simultaneous push/pop with count=1 for 10 cycles -> count stays 1, pointers wrap correctly, in-order tags 0..9 observed.
- Assert flush (and separately reset) with 2 entries buffered and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, flushed push not emitted; reset additionally drives out_result/out_tag/out_fflags=0.
